branch_ras_unit: RTL

Parametrised program-counter and branch-resolution unit for KGP-RISC, successor to the fixed 32-bit branch block. It holds the architectural PC, resolves unconditional, register-indirect and flag-conditional branches, and adds a hardware return-address stack (RAS) for call/return, a stall enable and sticky stack-error flags. It sits between the decoder/ALU flag register and instruction fetch.

---
 rtl/branch_ras_unit.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/branch_ras_unit.sv
// KGP-RISC program counter and branch resolution with optional return-address stack.
// Define BRANCH_RAS_EN to build the RAS; otherwise bl acts as b and ret as br.
module branch_ras_unit #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [1:0]                   branch_signal,
    input  logic [4:0]                   func_code,
    input  logic [2:0]                   alu_flag,
    input  logic [ADDR_W-1:0]            destination_addr,
    input  logic [ADDR_W-1:0]            reg_1,
    output logic [ADDR_W-1:0]            pc_op,
    output logic [ADDR_W-1:0]            pc_next,
    output logic                         taken,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);

    typedef enum logic [4:0] {
        FC_B    = 5'b10000,
        FC_BR   = 5'b10001,
        FC_BZ   = 5'b10010,
        FC_BNZ  = 5'b10011,
        FC_BCY  = 5'b10100,
        FC_BNCY = 5'b10101,
        FC_BLTZ = 5'b11000,
        FC_BGEZ = 5'b11001,
        FC_BL   = 5'b11010,
        FC_RET  = 5'b11011
    } func_e;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] seq;
    logic [ADDR_W-1:0] target;
    logic              jump;
    logic              taken_q;
    logic              zero_f, sign_f, carry_f;

    assign seq     = pc_q + PC_STEP;
    assign zero_f  = alu_flag[0];
    assign sign_f  = alu_flag[1];
    assign carry_f = alu_flag[2];

`ifdef BRANCH_RAS_EN
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [PTR_W-1:0]  top_q, top_d, top_m1;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              push, pop, full, empty;

    // top_q is the next free slot; when full it also points at the oldest entry.
    assign top_m1 = top_q - PTR_W'(1);
    assign full   = (cnt_q == CNT_W'(RAS_DEPTH));
    assign empty  = (cnt_q == '0);
`endif

    // NOTE: every output of a combinational block gets a default before the case, so no path can infer a latch.
    always_comb begin
        jump   = 1'b0;
        target = destination_addr;
`ifdef BRANCH_RAS_EN
        push   = 1'b0;
        pop    = 1'b0;
`endif
        if (branch_signal == 2'b11) begin
            case (func_code)
                FC_B:    jump = 1'b1;
                FC_BR:   begin jump = 1'b1; target = reg_1; end
                FC_BZ:   jump = zero_f;
                FC_BNZ:  jump = !zero_f;
                FC_BCY:  jump = carry_f;
                FC_BNCY: jump = !carry_f;
                FC_BLTZ: jump = sign_f;
                FC_BGEZ: jump = !sign_f;
                FC_BL: begin
                    jump = 1'b1;
`ifdef BRANCH_RAS_EN
                    push = 1'b1;
`endif
                end
                FC_RET: begin
`ifdef BRANCH_RAS_EN
                    pop    = 1'b1;
                    jump   = !empty;
                    target = ras_q[top_m1];
`else
                    jump   = 1'b1;
                    target = reg_1;
`endif
                end
                default: ;
            endcase
        end
        pc_next = jump ? target : seq;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            taken_q <= 1'b0;
        end else if (en) begin
            pc_q    <= pc_next;
            taken_q <= jump;
        end
    end

    assign pc_op = pc_q;
    assign taken = taken_q;

`ifdef BRANCH_RAS_EN
    always_comb begin
        top_d = top_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (push) begin
            top_d = top_q + PTR_W'(1);
            if (full) ovf_d = 1'b1;
            else      cnt_d = cnt_q + CNT_W'(1);
        end else if (pop) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                top_d = top_m1;
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            top_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (en) begin
            top_q <= top_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // NOTE: stack storage has no reset; cnt_q alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (!rst && en && push) ras_q[top_q] <= seq;
    end

    assign ras_count     = cnt_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;
`else
    assign ras_count     = '0;
    assign ras_overflow  = 1'b0;
    assign ras_underflow = 1'b0;
`endif

endmodule
